// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNARMED = 2'b00,
    FILL    = 2'b01,
    HUNT    = 2'b10
  } state_t;

  localparam int PAT_LEN_MIN = 1;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 16;

endpackage

// File: rtl/seq_detector_param_if.sv
// Control, serial data and match-report bundle between a stimulus source and the detector.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               overlap;
  logic               inp_valid;
  logic               inp;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  modport master (
    output pat_load, pat_in, overlap, inp_valid, inp, cnt_clr,
    input  out, match_cnt, armed
  );

  modport slave (
    input  pat_load, pat_in, overlap, inp_valid, inp, cnt_clr,
    output out, match_cnt, armed
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear takes priority over increment, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time pattern load, optional overlap and a
// registered one-cycle match pulse; one bit per clock, no backpressure.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int HW = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int FW = $clog2(PAT_LEN) + 1;
  localparam logic [FW-1:0] FILL_LAST  = FW'(PAT_LEN - 1);
  localparam state_t        LOAD_STATE = (PAT_LEN == 1) ? HUNT : FILL;

  state_t             state;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] cand;
  logic [HW-1:0]      hist;
  logic [FW-1:0]      fill_cnt;
  logic               out_q;
  logic               match;

  // Single-bit patterns have no history; the candidate is the bit itself.
  generate
    if (PAT_LEN == 1) begin : g_cand_single
      assign cand = bus.inp;
    end else begin : g_cand_shift
      assign cand = {hist[PAT_LEN-2:0], bus.inp};
    end
  endgenerate

  assign match = (state == HUNT) && bus.inp_valid && !bus.pat_load && (cand == pattern);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNARMED;
      pattern  <= '0;
      hist     <= '0;
      fill_cnt <= '0;
      out_q    <= 1'b0;
    end else begin
      out_q <= match;
      if (bus.pat_load) begin
        pattern  <= bus.pat_in;
        hist     <= '0;
        fill_cnt <= '0;
        state    <= LOAD_STATE;
      end else if (bus.inp_valid) begin
        case (state)
          FILL: begin
            hist     <= cand[HW-1:0];
            fill_cnt <= fill_cnt + FW'(1);
            if ((fill_cnt + FW'(1)) == FILL_LAST) begin
              state <= HUNT;
            end
          end
          HUNT: begin
            if (match && !bus.overlap && (PAT_LEN > 1)) begin
              hist     <= '0;
              fill_cnt <= '0;
              state    <= FILL;
            end else begin
              hist <= cand[HW-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.armed = (state != UNARMED);

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (match),
    .q   (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_LEN=4, CNT_W=2 to reach saturation quickly).
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) bus ();

  seq_detector_param #(.PAT_LEN(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pat_load  = 1'b0;
    bus.pat_in    = '0;
    bus.overlap   = 1'b1;
    bus.inp_valid = 1'b0;
    bus.inp       = 1'b0;
    bus.cnt_clr   = 1'b0;
  endtask

  task automatic load(input logic [3:0] p);
    bus.pat_load = 1'b1;
    bus.pat_in   = p;
    tick();
    bus.pat_load = 1'b0;
  endtask

  task automatic clr_cnt();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
  endtask

  task automatic send(input logic b);
    bus.inp_valid = 1'b1;
    bus.inp       = b;
    tick();
    bus.inp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (bus.out !== 1'b0) $display("FAIL reset_out got %b want 0", bus.out); else passed++;
    total++; if (bus.match_cnt !== 2'd0) $display("FAIL reset_cnt got %0d want 0", bus.match_cnt); else passed++;
    total++; if (bus.armed !== 1'b0) $display("FAIL reset_armed got %b want 0", bus.armed); else passed++;
    // Unarmed detector must ignore a stream that contains 0000.
    for (int i = 0; i < 5; i++) begin
      send(1'b0);
      total++; if (bus.out !== 1'b0) $display("FAIL unarmed_out bit %0d got %b want 0", i, bus.out); else passed++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    bus.overlap = 1'b1;
    load(4'b1011);
    total++; if (bus.armed !== 1'b1) $display("FAIL armed_after_load got %b want 1", bus.armed); else passed++;
    for (int i = 6; i >= 0; i--) begin
      send(bits[i]);
      total++; if (bus.out !== exp[i]) $display("FAIL overlap_out bit %0d got %b want %b", 6 - i, bus.out, exp[i]); else passed++;
    end
    total++; if (bus.match_cnt !== 2'd2) $display("FAIL overlap_cnt got %0d want 2", bus.match_cnt); else passed++;
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001000;
    clr_cnt();
    bus.overlap = 1'b0;
    load(4'b1011);
    for (int i = 6; i >= 0; i--) begin
      send(bits[i]);
      total++; if (bus.out !== exp[i]) $display("FAIL nooverlap_out bit %0d got %b want %b", 6 - i, bus.out, exp[i]); else passed++;
      if (i == 3) begin
        total++; if (dut.state !== FILL) $display("FAIL nooverlap_state got %0d want %0d", dut.state, FILL); else passed++;
      end
    end
    total++; if (bus.match_cnt !== 2'd1) $display("FAIL nooverlap_cnt got %0d want 1", bus.match_cnt); else passed++;
    bus.overlap = 1'b1;
  endtask

  task automatic test_saturate();
    logic [9:0] exp = 10'b0001111111;
    clr_cnt();
    load(4'b1111);
    for (int i = 9; i >= 0; i--) begin
      send(1'b1);
      total++; if (bus.out !== exp[i]) $display("FAIL sat_out bit %0d got %b want %b", 9 - i, bus.out, exp[i]); else passed++;
    end
    total++; if (bus.match_cnt !== 2'd3) $display("FAIL sat_cnt got %0d want 3", bus.match_cnt); else passed++;
    bus.cnt_clr = 1'b1;
    send(1'b1);
    bus.cnt_clr = 1'b0;
    total++; if (bus.out !== 1'b1) $display("FAIL clr_match_out got %b want 1", bus.out); else passed++;
    total++; if (bus.match_cnt !== 2'd0) $display("FAIL clr_match_cnt got %0d want 0", bus.match_cnt); else passed++;
  endtask

  task automatic test_gap();
    clr_cnt();
    load(4'b1011);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.out !== 1'b0) $display("FAIL gap_idle_out cycle %0d got %b want 0", i, bus.out); else passed++;
    end
    send(1'b1);
    total++; if (bus.out !== 1'b1) $display("FAIL gap_match_out got %b want 1", bus.out); else passed++;
    tick();
    total++; if (bus.out !== 1'b0) $display("FAIL gap_after_out got %b want 0", bus.out); else passed++;
    total++; if (bus.match_cnt !== 2'd1) $display("FAIL gap_cnt got %0d want 1", bus.match_cnt); else passed++;
  endtask

  task automatic test_load_collide();
    logic [3:0] bits = 4'b0110;
    logic [3:0] exp  = 4'b0001;
    clr_cnt();
    load(4'b1011);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    // This bit would complete 1011, but the concurrent load must discard it.
    bus.pat_load  = 1'b1;
    bus.pat_in    = 4'b0110;
    bus.inp_valid = 1'b1;
    bus.inp       = 1'b1;
    tick();
    bus.pat_load  = 1'b0;
    bus.inp_valid = 1'b0;
    total++; if (bus.out !== 1'b0) $display("FAIL collide_out got %b want 0", bus.out); else passed++;
    total++; if (bus.match_cnt !== 2'd0) $display("FAIL collide_cnt got %0d want 0", bus.match_cnt); else passed++;
    for (int i = 3; i >= 0; i--) begin
      send(bits[i]);
      total++; if (bus.out !== exp[i]) $display("FAIL newpat_out bit %0d got %b want %b", 3 - i, bus.out, exp[i]); else passed++;
    end
    total++; if (bus.match_cnt !== 2'd1) $display("FAIL newpat_cnt got %0d want 1", bus.match_cnt); else passed++;
  endtask

  task automatic test_rst_mid();
    logic [3:0] bits = 4'b1011;
    load(4'b1011);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    rst           = 1'b1;
    bus.inp_valid = 1'b1;
    bus.inp       = 1'b1;
    tick();
    rst           = 1'b0;
    bus.inp_valid = 1'b0;
    total++; if (bus.out !== 1'b0) $display("FAIL rstmid_out got %b want 0", bus.out); else passed++;
    total++; if (bus.match_cnt !== 2'd0) $display("FAIL rstmid_cnt got %0d want 0", bus.match_cnt); else passed++;
    total++; if (bus.armed !== 1'b0) $display("FAIL rstmid_armed got %b want 0", bus.armed); else passed++;
    for (int i = 3; i >= 0; i--) begin
      send(bits[i]);
      total++; if (bus.out !== 1'b0) $display("FAIL rstmid_noreload_out bit %0d got %b want 0", 3 - i, bus.out); else passed++;
    end
    total++; if (bus.match_cnt !== 2'd0) $display("FAIL rstmid_noreload_cnt got %0d want 0", bus.match_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_overlap();
    test_no_overlap();
    test_saturate();
    test_gap();
    test_load_collide();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
